// File: rtl/rgmii_rx_framer.sv
// rgmii_rx_framer
// ---------------------------------------------------------------------------
// RGMII receive front end. Captures the 4-bit DDR receive bus on both edges of
// mac_clk, rebuilds bytes with data-valid and receive-error qualifiers, strips
// the preamble and SFD, and emits packet-delimited bytes toward the MAC.
//
// Parameters:
//   DATA_WIDTH : output byte width (only 8 is supported)
//   SFD        : start-of-frame delimiter byte
// Ports:
//   mac_clk            in  : buffered RGMII receive clock (both edges used)
//   mac_rst_n          in  : asynchronous active-low reset
//   rx_rgmii_data[3:0] in  : RGMII RXD
//   rx_rgmii_ctl       in  : RGMII RX_CTL
//   mac_startofpacket  out : first payload byte (byte after SFD)
//   mac_endofpacket    out : last byte of the frame
//   mac_valid          out : mac_data carries a frame byte
//   mac_data           out : frame byte
//   mac_error          out : PHY receive error on this byte
// Optional feature:
//   RGMII_RX_PREAMBLE_CHECK_EN : when defined, an SFD only starts a frame if it
//   is preceded by at least two consecutive 0x55 preamble bytes.
// ---------------------------------------------------------------------------
module rgmii_rx_framer #(
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] SFD        = 8'hD5
) (
  input  logic                  mac_clk,
  input  logic                  mac_rst_n,
  input  logic [3:0]            rx_rgmii_data,
  input  logic                  rx_rgmii_ctl,
  output logic                  mac_startofpacket,
  output logic                  mac_endofpacket,
  output logic                  mac_valid,
  output logic [DATA_WIDTH-1:0] mac_data,
  output logic                  mac_error
);

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_IN_PACKET = 1'b1
  } state_t;

  logic [3:0] lo_r;
  logic       dv_r;
  logic [3:0] hi_r;
  logic       ctl_f_r;
  logic [7:0] b_data_r;
  logic       b_dv_r;
  logic       b_err_r;
  state_t     state_r;
  logic       sop_flag_r;
  logic       pre_ok_s;
  logic       sfd_hit_s;

  // Rising-edge capture: low nibble and RX_CTL (= DV).
  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      lo_r <= 4'h0;
      dv_r <= 1'b0;
    end else begin
      lo_r <= rx_rgmii_data;
      dv_r <= rx_rgmii_ctl;
    end
  end

  // Falling-edge capture: high nibble and RX_CTL (= DV xor ER).
  always_ff @(negedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      hi_r    <= 4'h0;
      ctl_f_r <= 1'b0;
    end else begin
      hi_r    <= rx_rgmii_data;
      ctl_f_r <= rx_rgmii_ctl;
    end
  end

  // Byte stage: rebuild the byte and decode ER from the two CTL samples.
  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      b_data_r <= 8'h00;
      b_dv_r   <= 1'b0;
      b_err_r  <= 1'b0;
    end else begin
      b_data_r <= {hi_r, lo_r};
      b_dv_r   <= dv_r;
      b_err_r  <= dv_r ^ ctl_f_r;
    end
  end

`ifdef RGMII_RX_PREAMBLE_CHECK_EN
  logic [2:0] pre_cnt_r;

  // Saturating count of consecutive valid 0x55 bytes seen at the byte stage.
  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      pre_cnt_r <= 3'd0;
    end else if (b_dv_r && (b_data_r == 8'h55)) begin
      if (pre_cnt_r != 3'd7) begin
        pre_cnt_r <= pre_cnt_r + 3'd1;
      end else begin
        pre_cnt_r <= pre_cnt_r;
      end
    end else begin
      pre_cnt_r <= 3'd0;
    end
  end

  // Count reflects the bytes strictly before the current byte-stage byte.
  assign pre_ok_s = (pre_cnt_r >= 3'd2);
`else
  assign pre_ok_s = 1'b1;
`endif

  // SFD recognition at the byte stage.
  always_comb begin
    sfd_hit_s = 1'b0;
    if (b_dv_r && (b_data_r == SFD) && pre_ok_s) begin
      sfd_hit_s = 1'b1;
    end else begin
      sfd_hit_s = 1'b0;
    end
  end

  // Framer FSM with registered outputs. dv_r is the DV of the byte that will
  // follow the one in the byte stage, so it decides frame start and EOP.
  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      state_r           <= ST_IDLE;
      sop_flag_r        <= 1'b0;
      mac_valid         <= 1'b0;
      mac_data          <= {DATA_WIDTH{1'b0}};
      mac_startofpacket <= 1'b0;
      mac_endofpacket   <= 1'b0;
      mac_error         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          mac_valid         <= 1'b0;
          mac_data          <= {DATA_WIDTH{1'b0}};
          mac_startofpacket <= 1'b0;
          mac_endofpacket   <= 1'b0;
          mac_error         <= 1'b0;
          // An SFD with no following byte is an empty frame: dropped.
          if (sfd_hit_s && dv_r) begin
            state_r    <= ST_IN_PACKET;
            sop_flag_r <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
            sop_flag_r <= 1'b0;
          end
        end
        ST_IN_PACKET: begin
          sop_flag_r <= 1'b0;
          if (b_dv_r) begin
            mac_valid         <= 1'b1;
            mac_data          <= b_data_r;
            mac_startofpacket <= sop_flag_r;
            mac_endofpacket   <= ~dv_r;
            mac_error         <= b_err_r;
          end else begin
            mac_valid         <= 1'b0;
            mac_data          <= {DATA_WIDTH{1'b0}};
            mac_startofpacket <= 1'b0;
            mac_endofpacket   <= 1'b0;
            mac_error         <= 1'b0;
          end
          if (!dv_r) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_IN_PACKET;
          end
        end
        default: begin
          state_r           <= ST_IDLE;
          sop_flag_r        <= 1'b0;
          mac_valid         <= 1'b0;
          mac_data          <= {DATA_WIDTH{1'b0}};
          mac_startofpacket <= 1'b0;
          mac_endofpacket   <= 1'b0;
          mac_error         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Testbench for rgmii_rx_framer: directed frames from the test plan plus
// randomized frame streams, checked against a frame-level reference model.
module tb_rgmii_rx_framer;

  localparam logic [7:0] SFD_C = 8'hD5;

  logic       mac_clk = 1'b0;
  logic       mac_rst_n = 1'b1;
  logic [3:0] rx_rgmii_data = 4'h0;
  logic       rx_rgmii_ctl = 1'b0;
  logic       mac_startofpacket;
  logic       mac_endofpacket;
  logic       mac_valid;
  logic [7:0] mac_data;
  logic       mac_error;

  rgmii_rx_framer #(.DATA_WIDTH(8), .SFD(SFD_C)) dut (
    .mac_clk           (mac_clk),
    .mac_rst_n         (mac_rst_n),
    .rx_rgmii_data     (rx_rgmii_data),
    .rx_rgmii_ctl      (rx_rgmii_ctl),
    .mac_startofpacket (mac_startofpacket),
    .mac_endofpacket   (mac_endofpacket),
    .mac_valid         (mac_valid),
    .mac_data          (mac_data),
    .mac_error         (mac_error)
  );

  initial forever #5 mac_clk = ~mac_clk;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       err;
  } rec_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   eop_cnt = 0;
  bit   mon_en = 1'b0;
  rec_t obs_q[$];
  rec_t exp_q[$];
  logic [7:0] ph_d[$];
  bit         ph_v[$];
  bit         ph_e[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: collect valid bytes; idle cycles must present all-zero outputs.
  always @(negedge mac_clk) begin
    if (mon_en) begin
      if (mac_valid === 1'b1) begin
        rec_t r;
        r.cyc = cyc; r.d = mac_data; r.sop = mac_startofpacket;
        r.eop = mac_endofpacket; r.err = mac_error;
        obs_q.push_back(r);
        if (mac_endofpacket) eop_cnt++;
      end else begin
        chk("idle_zero", {20'd0, mac_startofpacket, mac_endofpacket, mac_error, mac_valid, mac_data}, 32'd0);
      end
    end
  end

  // One RGMII byte time: low nibble + DV before the rising edge,
  // high nibble + (DV xor ER) before the falling edge.
  task automatic drive_cycle(input logic [7:0] d, input bit v, input bit e);
    rx_rgmii_data = d[3:0];
    rx_rgmii_ctl  = v;
    @(posedge mac_clk);
    cyc++;
    #1;
    rx_rgmii_data = d[7:4];
    rx_rgmii_ctl  = v ^ e;
    @(negedge mac_clk);
    #1;
  endtask

  task automatic add_byte(input logic [7:0] d, input bit v, input bit e);
    ph_d.push_back(d); ph_v.push_back(v); ph_e.push_back(e);
  endtask

  // Idle cycles with random data and occasional false-carrier ER.
  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add_byte(8'($urandom), 1'b0, ($urandom_range(0, 3) == 0));
  endtask

  task automatic add_frame(input int npre, input logic [7:0] pay[$], input int err_idx);
    for (int i = 0; i < npre; i++) add_byte(8'h55, 1'b1, 1'b0);
    add_byte(SFD_C, 1'b1, 1'b0);
    for (int i = 0; i < pay.size(); i++) add_byte(pay[i], 1'b1, (i == err_idx));
  endtask

  task automatic begin_phase();
    ph_d.delete(); ph_v.delete(); ph_e.delete();
    add_idle(3);
  endtask

  // Reference model: a frame is a contiguous DV run; the first acceptable SFD
  // in it starts the frame, the remaining bytes of the run are the payload.
  task automatic build_expected(input int base);
    int   n, i, j, k;
    bit   ok, first;
    rec_t r;
    exp_q.delete();
    n = ph_d.size();
    i = 0;
    while (i < n) begin
      ok = ph_v[i] && (ph_d[i] == SFD_C);
`ifdef RGMII_RX_PREAMBLE_CHECK_EN
      k = 0;
      while ((i - 1 - k >= 0) && ph_v[i-1-k] && (ph_d[i-1-k] == 8'h55)) k++;
      if (k < 2) ok = 1'b0;
`else
      k = 0;
`endif
      if (ok && (i + 1 < n) && ph_v[i+1]) begin
        j = i + 1;
        first = 1'b1;
        while (j < n && ph_v[j]) begin
          r.cyc = base + j + 2; r.d = ph_d[j]; r.sop = first;
          r.eop = !((j + 1 < n) && ph_v[j+1]); r.err = ph_e[j];
          exp_q.push_back(r);
          first = 1'b0;
          j++;
        end
        i = j;
      end else begin
        i++;
      end
    end
  endtask

  // Drive the phase stream (drained by trailing idles) and compare.
  task automatic run_phase(input string name);
    int base;
    add_idle(4);
    obs_q.delete();
    base = cyc + 1;
    for (int i = 0; i < ph_d.size(); i++) drive_cycle(ph_d[i], ph_v[i], ph_e[i]);
    build_expected(base);
    chk({name, ".count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s.cyc[%0d]", name, i), obs_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s.data[%0d]", name, i), {24'd0, obs_q[i].d}, {24'd0, exp_q[i].d});
      chk($sformatf("%s.sop[%0d]", name, i), {31'd0, obs_q[i].sop}, {31'd0, exp_q[i].sop});
      chk($sformatf("%s.eop[%0d]", name, i), {31'd0, obs_q[i].eop}, {31'd0, exp_q[i].eop});
      chk($sformatf("%s.err[%0d]", name, i), {31'd0, obs_q[i].err}, {31'd0, exp_q[i].err});
    end
  endtask

  initial begin
    logic [7:0] pay[$];
    int nf;

    #1;
    mac_rst_n = 1'b0;
    #2;
    chk("reset.valid", {31'd0, mac_valid}, 32'd0);
    chk("reset.sop_eop_err", {29'd0, mac_startofpacket, mac_endofpacket, mac_error}, 32'd0);
    chk("reset.data", {24'd0, mac_data}, 32'd0);
    mon_en = 1'b1;
    @(negedge mac_clk); #1;
    @(negedge mac_clk); #1;
    mac_rst_n = 1'b1;

    // Basic frame: 7x55, D5, 01..04 (SOP on 01, EOP on 04, 2-cycle latency).
    begin_phase();
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    add_frame(7, pay, -1);
    run_phase("basic");
    chk("basic.n", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("basic.first", {24'd0, obs_q[0].d}, 32'h01);
      chk("basic.last_eop", {31'd0, obs_q[3].eop}, 32'd1);
    end

    // Single-byte frame: SOP and EOP on the same byte.
    begin_phase();
    pay = '{8'hAA};
    add_frame(7, pay, -1);
    run_phase("single");
    chk("single.n", obs_q.size(), 1);
    if (obs_q.size() == 1) chk("single.sop_eop", {30'd0, obs_q[0].sop, obs_q[0].eop}, 32'd3);

    // Receive error on byte 03 only.
    begin_phase();
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    add_frame(7, pay, 2);
    run_phase("rxerr");
    if (obs_q.size() == 4) chk("rxerr.on_03", {28'd0, obs_q[0].err, obs_q[1].err, obs_q[2].err, obs_q[3].err}, 32'h2);
    else chk("rxerr.n", obs_q.size(), 4);

    // Back-to-back frames with a single idle cycle between them.
    begin_phase();
    pay = '{8'h10, 8'h11, 8'h12};
    add_frame(7, pay, -1);
    add_idle(1);
    pay = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    add_frame(2, pay, -1);
    run_phase("b2b");
    chk("b2b.n", obs_q.size(), 8);

    // Empty frame (SFD immediately followed by DV low) produces nothing.
    begin_phase();
    pay.delete();
    add_frame(7, pay, -1);
    run_phase("empty");
    chk("empty.n", obs_q.size(), 0);

    // Reset while the 2nd payload byte is on the outputs.
    begin_phase();
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    add_frame(7, pay, -1);
    obs_q.delete();
    eop_cnt = 0;
    for (int i = 0; i <= 14; i++) drive_cycle(ph_d[i], ph_v[i], ph_e[i]);
    mac_rst_n = 1'b0;
    #1;
    chk("rst_mid.valid", {31'd0, mac_valid}, 32'd0);
    chk("rst_mid.outs", {21'd0, mac_startofpacket, mac_endofpacket, mac_error, mac_data}, 32'd0);
    for (int i = 0; i < 3; i++) drive_cycle(8'h00, 1'b0, 1'b0);
    mac_rst_n = 1'b1;
    chk("rst_mid.seen", obs_q.size(), 2);
    chk("rst_mid.no_eop", eop_cnt, 0);
    if (obs_q.size() == 2) chk("rst_mid.bytes", {16'd0, obs_q[0].d, obs_q[1].d}, 32'h1122);
    begin_phase();
    pay = '{8'hA1, 8'hA2, 8'hA3};
    add_frame(7, pay, -1);
    run_phase("after_rst");
    chk("after_rst.n", obs_q.size(), 3);

    // SFD without preamble, then with two preamble bytes.
    begin_phase();
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    add_frame(0, pay, -1);
    run_phase("no_pre");
`ifdef RGMII_RX_PREAMBLE_CHECK_EN
    chk("no_pre.n", obs_q.size(), 0);
`else
    chk("no_pre.n", obs_q.size(), 4);
`endif
    begin_phase();
    add_frame(2, pay, -1);
    run_phase("pre2");
    chk("pre2.n", obs_q.size(), 4);

    // Randomized streams: junk runs, false carrier, short gaps, varied
    // preamble lengths, empty frames and in-frame errors.
    for (int p = 0; p < 25; p++) begin
      begin_phase();
      nf = $urandom_range(1, 4);
      for (int f = 0; f < nf; f++) begin
        if ($urandom_range(0, 3) == 0) begin
          for (int q = 0; q < $urandom_range(1, 3); q++)
            add_byte(($urandom_range(0, 2) == 0) ? SFD_C : 8'($urandom), 1'b1, ($urandom_range(0, 7) == 0));
          add_idle($urandom_range(1, 2));
        end
        pay.delete();
        for (int q = 0; q < $urandom_range(0, 6); q++) pay.push_back(8'($urandom));
        add_frame($urandom_range(0, 7), pay, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : -1);
        add_idle($urandom_range(1, 3));
      end
      run_phase($sformatf("rand%0d", p));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
